// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receiver and frame assembler.
// The receiver runs from a runtime baud divisor with 16x oversampling. Each
// data and stop bit is decided by a 3-sample majority vote. A start edge that
// is not low at mid-bit is rejected. A framing error, or a long idle gap, drops
// the partial frame. The assembled frame is handed over through a valid/ack
// handshake.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the receiver
// expects one even-parity bit between the data bits and the stop bit.
module uart_rx_framer #(
    parameter int DIV_W       = 16,
    parameter int FRAME_BYTES = 13,
    parameter int IDLE_BITS   = 20
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic [DIV_W-1:0]                   BaudDiv,
    input  logic                               Rxd,
    output logic                               FrameValid,
    input  logic                               FrameAck,
    output logic [8*FRAME_BYTES-1:0]           FrameData,
    output logic [$clog2(FRAME_BYTES+1)-1:0]   ByteCnt,
    output logic                               FrameErr,
    output logic                               Overrun
);

    localparam int CNT_W      = $clog2(FRAME_BYTES + 1);
    localparam int BUF_W      = 8 * FRAME_BYTES;
    localparam int IDLE_LIMIT = IDLE_BITS * 16;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rxState_t;
`endif

    rxState_t stateReg, stateNext;

    // Synchroniser and edge-detect history; all three sit at 1 (line idle) after reset.
    logic rxdMetaReg, rxdSyncReg, rxdPrevReg;

    // Baud timing.
    logic [DIV_W-1:0] tickCntReg;
    logic [DIV_W-1:0] divReg;
    logic [3:0]       osCntReg;
    logic             tick;

    // Bit sampling and byte shift.
    logic       sampAReg, sampBReg;
    logic       sampleMaj;
    logic [2:0] bitIdxReg;
    logic [7:0] shiftReg;

    // Frame assembly and outputs.
    logic [BUF_W-1:0] asmBufReg;
    logic [BUF_W-1:0] asmBufNext;
    logic [BUF_W-1:0] frameDataReg;
    logic [CNT_W-1:0] byteCntReg;
    logic             frameValidReg, frameErrReg, overrunReg;

    // Idle-gap watchdog.
    logic [DIV_W-1:0]  idleDivCntReg;
    logic [IDLE_W-1:0] idleTickCntReg;
    logic              idleArmed, idleTick, idleExpire;

    // Decoded events.
    logic startEdge, atMidVote, atBitEnd, stopOk, stopGood, stopBad;
    logic frameDone, validBusy;

    assign startEdge = rxdPrevReg & ~rxdSyncReg;
    assign tick      = (stateReg != IDLE) && (tickCntReg == divReg);
    assign atMidVote = tick && (osCntReg == 4'd9);
    assign atBitEnd  = tick && (osCntReg == 4'd15);
    assign sampleMaj = (sampAReg & sampBReg) | (sampAReg & rxdSyncReg) | (sampBReg & rxdSyncReg);

`ifdef UART_RX_PARITY_EN
    logic parityOkReg;
    assign stopOk = sampleMaj & parityOkReg;
`else
    assign stopOk = sampleMaj;
`endif

    assign stopGood  = (stateReg == STOP) && atMidVote && stopOk;
    assign stopBad   = (stateReg == STOP) && atMidVote && !stopOk;
    assign frameDone = stopGood && (byteCntReg == LAST_BYTE);
    // An acknowledge in the same cycle frees the holding register for a new frame.
    assign validBusy = frameValidReg && !FrameAck;

    // The new byte goes into the low end of the buffer, so the oldest byte ends up in the MSBs.
    generate
        if (FRAME_BYTES > 1) begin : gen_multi
            assign asmBufNext = {asmBufReg[BUF_W-9:0], shiftReg};
        end else begin : gen_single
            assign asmBufNext = shiftReg;
        end
    endgenerate

    assign idleArmed  = (stateReg == IDLE) && rxdSyncReg && (byteCntReg != '0);
    assign idleTick   = idleArmed && (idleDivCntReg == divReg);
    assign idleExpire = idleTick && (idleTickCntReg == IDLE_LAST);

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // FSM next-state logic.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (startEdge) begin
                    stateNext = START;
                end
            end
            START: begin
                // A line that is high again at mid start bit was a glitch: drop it silently.
                if (tick && (osCntReg == 4'd7) && rxdSyncReg) begin
                    stateNext = IDLE;
                end else if (atBitEnd) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (atBitEnd && (bitIdxReg == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    stateNext = PARITY;
`else
                    stateNext = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (atBitEnd) begin
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at the vote so the next start edge can be caught immediately.
                // After a bad stop the line may still be low. IDLE only reacts to a 1->0
                // edge, so it waits for the line to go high first.
                if (atMidVote) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Two-flop synchroniser for the asynchronous pin, plus one history flop for edge detection.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rxdMetaReg <= 1'b1;
            rxdSyncReg <= 1'b1;
            rxdPrevReg <= 1'b1;
        end else begin
            rxdMetaReg <= Rxd;
            rxdSyncReg <= rxdMetaReg;
            rxdPrevReg <= rxdSyncReg;
        end
    end

    // Oversample tick generator. It is parked at 0 while idle, and a new divisor is taken only at a wrap.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tickCntReg <= '0;
            divReg     <= '0;
        end else begin
            if (stateReg == IDLE || tick) begin
                tickCntReg <= '0;
                divReg     <= BaudDiv;
            end else begin
                tickCntReg <= tickCntReg + 1'b1;
            end
        end
    end

    // Oversample position within the current bit. The first two vote samples are captured here.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            osCntReg <= '0;
            sampAReg <= 1'b1;
            sampBReg <= 1'b1;
        end else begin
            if (stateReg == IDLE) begin
                osCntReg <= '0;
            end else if (tick) begin
                osCntReg <= osCntReg + 1'b1;
                if (osCntReg == 4'd7) begin
                    sampAReg <= rxdSyncReg;
                end
                if (osCntReg == 4'd8) begin
                    sampBReg <= rxdSyncReg;
                end
            end
        end
    end

    // Data bit shifting, LSB first, and bit index tracking.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            shiftReg  <= '0;
            bitIdxReg <= '0;
        end else begin
            if (stateReg == IDLE) begin
                bitIdxReg <= '0;
            end else if (stateReg == DATA) begin
                if (atMidVote) begin
                    shiftReg <= {sampleMaj, shiftReg[7:1]};
                end
                if (atBitEnd) begin
                    bitIdxReg <= bitIdxReg + 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity check: the voted parity bit must equal the XOR of the data bits.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            parityOkReg <= 1'b0;
        end else if ((stateReg == PARITY) && atMidVote) begin
            parityOkReg <= (sampleMaj == ^shiftReg);
        end
    end
`endif

    // Frame assembly, holding register, handshake, overrun and error pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            asmBufReg     <= '0;
            frameDataReg  <= '0;
            byteCntReg    <= '0;
            frameValidReg <= 1'b0;
            frameErrReg   <= 1'b0;
            overrunReg    <= 1'b0;
        end else begin
            frameErrReg <= stopBad;

            if (FrameAck && frameValidReg) begin
                frameValidReg <= 1'b0;
                overrunReg    <= 1'b0;
            end

            if (stopGood) begin
                asmBufReg <= asmBufNext;
                if (frameDone) begin
                    byteCntReg <= '0;
                    if (validBusy) begin
                        overrunReg <= 1'b1;
                    end else begin
                        frameDataReg  <= asmBufNext;
                        frameValidReg <= 1'b1;
                    end
                end else begin
                    byteCntReg <= byteCntReg + 1'b1;
                end
            end else if (stopBad || idleExpire) begin
                byteCntReg <= '0;
            end
        end
    end

    // Idle-gap watchdog. It counts oversample periods of continuous high line while a partial frame is held.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            idleDivCntReg  <= '0;
            idleTickCntReg <= '0;
        end else begin
            if (!idleArmed) begin
                idleDivCntReg  <= '0;
                idleTickCntReg <= '0;
            end else if (idleTick) begin
                idleDivCntReg <= '0;
                if (idleExpire) begin
                    idleTickCntReg <= '0;
                end else begin
                    idleTickCntReg <= idleTickCntReg + 1'b1;
                end
            end else begin
                idleDivCntReg <= idleDivCntReg + 1'b1;
            end
        end
    end

    assign FrameValid = frameValidReg;
    assign FrameData  = frameDataReg;
    assign ByteCnt    = byteCntReg;
    assign FrameErr   = frameErrReg;
    assign Overrun    = overrunReg;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed testbench for uart_rx_framer (default parameters, 13-byte frames).
// The parity step is built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_framer;

    logic         Clk;
    logic         Rst;
    logic [15:0]  BaudDiv;
    logic         Rxd;
    logic         FrameValid;
    logic         FrameAck;
    logic [103:0] FrameData;
    logic [3:0]   ByteCnt;
    logic         FrameErr;
    logic         Overrun;

    int checks   = 0;
    int failures = 0;
    int errCnt   = 0;
    int riseCnt  = 0;
    int errBase;
    int riseBase;
    logic prevValid = 1'b0;

    uart_rx_framer dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .BaudDiv    (BaudDiv),
        .Rxd        (Rxd),
        .FrameValid (FrameValid),
        .FrameAck   (FrameAck),
        .FrameData  (FrameData),
        .ByteCnt    (ByteCnt),
        .FrameErr   (FrameErr),
        .Overrun    (Overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count the cycles with FrameErr high, and the rising edges of FrameValid.
    always @(negedge Clk) begin
        if (FrameErr === 1'b1) errCnt++;
        if (FrameValid === 1'b1 && prevValid !== 1'b1) riseCnt++;
        prevValid = FrameValid;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic waitBits(input int nBits);
        repeat (nBits * 16 * (int'(BaudDiv) + 1)) @(negedge Clk);
    endtask

    // Send one character: start bit, 8 data bits LSB first, optional parity bit, then the stop bit.
    task automatic sendByte(input logic [7:0] data, input logic stopBit, input logic parBit);
        Rxd = 1'b0;
        waitBits(1);
        for (int i = 0; i < 8; i++) begin
            Rxd = data[i];
            waitBits(1);
        end
`ifdef UART_RX_PARITY_EN
        Rxd = parBit;
        waitBits(1);
`else
        if (parBit === 1'bx) Rxd = 1'b1;
`endif
        Rxd = stopBit;
        waitBits(1);
        Rxd = 1'b1;
    endtask

    task automatic sendGood(input logic [7:0] data);
        sendByte(data, 1'b1, ^data);
    endtask

    task automatic sendRun(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) begin
            sendGood(first + 8'(i));
        end
    endtask

    task automatic pulseAck();
        FrameAck = 1'b1;
        @(negedge Clk);
        FrameAck = 1'b0;
    endtask

    initial begin
        Rst      = 1'b1;
        Rxd      = 1'b1;
        FrameAck = 1'b0;
        BaudDiv  = 16'd2;
        repeat (4) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Reset state
        chk("rst_valid", FrameValid, 0);
        chk("rst_data", FrameData, 0);
        chk("rst_bytecnt", ByteCnt, 0);
        chk("rst_err", FrameErr, 0);
        chk("rst_overrun", Overrun, 0);

        // 1: thirteen bytes 0x00..0x0C form one frame
        riseBase = riseCnt;
        sendRun(8'h00, 3);
        chk("t1_cnt3", ByteCnt, 3);
        sendRun(8'h03, 10);
        @(negedge Clk);
        chk("t1_valid", FrameValid, 1);
        chk("t1_data", FrameData, 104'h000102030405060708090A0B0C);
        chk("t1_bytecnt", ByteCnt, 0);
        chk("t1_rises", riseCnt - riseBase, 1);
        chk("t1_errs", errCnt, 0);
        pulseAck();
        chk("t1_ackclr", FrameValid, 0);

        // 2: short low glitch (4 ticks) is rejected
        Rxd = 1'b0;
        repeat (4 * (int'(BaudDiv) + 1)) @(negedge Clk);
        Rxd = 1'b1;
        waitBits(3);
        chk("t2_bytecnt", ByteCnt, 0);
        chk("t2_errs", errCnt, 0);
        chk("t2_valid", FrameValid, 0);

        // 3: framing error after 5 good bytes, then a clean frame
        sendRun(8'hA0, 5);
        chk("t3_cnt5", ByteCnt, 5);
        errBase = errCnt;
        sendByte(8'h55, 1'b0, 1'b0);
        waitBits(1);
        chk("t3_errpulse", errCnt - errBase, 1);
        chk("t3_bytecnt", ByteCnt, 0);
        chk("t3_novalid", FrameValid, 0);
        sendRun(8'h10, 13);
        @(negedge Clk);
        chk("t3_valid", FrameValid, 1);
        chk("t3_data", FrameData, 104'h101112131415161718191A1B1C);
        pulseAck();

        // 4: second frame without an ack overruns and is discarded
        sendRun(8'h20, 13);
        @(negedge Clk);
        chk("t4_validA", FrameValid, 1);
        chk("t4_ovr0", Overrun, 0);
        sendRun(8'h30, 13);
        @(negedge Clk);
        chk("t4_keepA", FrameData, 104'h202122232425262728292A2B2C);
        chk("t4_ovr1", Overrun, 1);
        chk("t4_bytecnt", ByteCnt, 0);
        pulseAck();
        chk("t4_ackvalid", FrameValid, 0);
        chk("t4_ackovr", Overrun, 0);

        // 5: an idle gap drops a partial frame (slower divisor)
        BaudDiv = 16'd4;
        @(negedge Clk);
        errBase = errCnt;
        sendRun(8'h40, 4);
        chk("t5_cnt4", ByteCnt, 4);
        waitBits(25);
        chk("t5_resync", ByteCnt, 0);
        chk("t5_noerr", errCnt - errBase, 0);
        sendRun(8'h50, 13);
        @(negedge Clk);
        chk("t5_valid", FrameValid, 1);
        chk("t5_data", FrameData, 104'h505152535455565758595A5B5C);

`ifdef UART_RX_PARITY_EN
        // 6a: bad parity causes a framing error, good parity is accepted
        pulseAck();
        errBase = errCnt;
        sendByte(8'h03, 1'b1, 1'b1);
        waitBits(1);
        chk("t6_parerr", errCnt - errBase, 1);
        chk("t6_parcnt0", ByteCnt, 0);
        sendByte(8'h03, 1'b1, 1'b0);
        waitBits(1);
        chk("t6_parok", ByteCnt, 1);
        chk("t6_parnoerr", errCnt - errBase, 1);
        sendRun(8'h60, 12);
        @(negedge Clk);
        chk("t6_parvalid", FrameValid, 1);
`endif

        // 6b: reset in the middle of a byte while a frame is held
        BaudDiv = 16'd2;
        @(negedge Clk);
        sendRun(8'h70, 2);
        chk("t7_cnt2", ByteCnt, 2);
        Rxd = 1'b0;
        waitBits(3);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rxd = 1'b1;
        @(negedge Clk);
        chk("t7_valid", FrameValid, 0);
        chk("t7_data", FrameData, 0);
        chk("t7_bytecnt", ByteCnt, 0);
        chk("t7_err", FrameErr, 0);
        chk("t7_overrun", Overrun, 0);
        Rst = 1'b0;
        waitBits(2);
        errBase = errCnt;
        sendGood(8'h77);
        waitBits(1);
        chk("t7_recover", ByteCnt, 1);
        chk("t7_recnoerr", errCnt - errBase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
